// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: reassembles LSB-first serial frames into WIDTH-bit words behind a valid/ready register.
// Optional trailing even-parity bit per frame when S2P_PARITY_CHECK_EN is defined.
module serial_to_parallel_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             valid_in,
    input  logic             empty_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overflow_err,
    output logic             parity_err
);
`ifdef S2P_PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_oerr;
    logic             r_perr;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_ok;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) w_next[i] = (r_cnt == CNT_W'(i)) ? serial_in : r_shift[i];
    end
    assign w_last = r_cnt == CNT_W'(FRAME_LEN - 1);
`ifdef S2P_PARITY_CHECK_EN
    // the parity bit is never stored: all data bits are already in r_shift
    assign w_word = r_shift;
    assign w_ok   = ~(^r_shift ^ serial_in);
`else
    assign w_word = w_next;
    assign w_ok   = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            if (r_valid && out_ready) r_valid <= 1'b0;
            if (valid_in) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    if (!w_ok) r_perr <= 1'b1;
                    else if (r_valid && !out_ready) r_oerr <= 1'b1;
                    else begin
                        r_data  <= w_word;
                        r_valid <= 1'b1;
                    end
                end else begin
                    r_shift <= w_next;
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= SHIFT;
                end
            end else if (r_state == SHIFT && empty_in) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_ferr  <= 1'b1;
            end
        end
    end
    assign parallel_out = r_data;
    assign out_valid    = r_valid;
    assign frame_err    = r_ferr;
    assign overflow_err = r_oerr;
    assign parity_err   = r_perr;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed and random stimulus against a bit-queue reference model (default build, WIDTH=4).
module tb_serial_to_parallel_rx;
    localparam int WIDTH = 4;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             serial_in = 1'b0;
    logic             valid_in = 1'b0;
    logic             empty_in = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             frame_err;
    logic             overflow_err;
    logic             parity_err;
    int               n_checks = 0;
    int               n_errors = 0;
    int               q[$];
    logic [WIDTH-1:0] m_pout = '0;
    logic             m_valid = 1'b0;
    logic             m_ferr = 1'b0;
    logic             m_oerr = 1'b0;

    serial_to_parallel_rx #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .valid_in(valid_in),
        .empty_in(empty_in), .parallel_out(parallel_out), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err), .overflow_err(overflow_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rs, input logic v, input logic s, input logic e, input logic r);
        logic             acc;
        logic [WIDTH-1:0] word;
        if (rs) begin
            q.delete();
            m_pout = '0; m_valid = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
            return;
        end
        acc    = m_valid && r;
        m_ferr = 1'b0;
        if (v) begin
            q.push_back(int'(s));
            if (q.size() == WIDTH) begin
                word = '0;
                foreach (q[i]) word = word + WIDTH'(q[i] << i);
                q.delete();
                if (m_valid && !r) m_oerr = 1'b1;
                else begin
                    m_pout  = word;
                    m_valid = 1'b1;
                    acc     = 1'b0;
                end
            end
        end else if (e && q.size() > 0) begin
            q.delete();
            m_ferr = 1'b1;
        end
        if (acc) m_valid = 1'b0;
    endtask

    task automatic step(input logic rs, input logic v, input logic s, input logic e, input logic r);
        @(negedge clk);
        reset = rs; valid_in = v; serial_in = s; empty_in = e; out_ready = r;
        @(posedge clk);
        model(rs, v, s, e, r);
        #1;
        check("parallel_out", int'(parallel_out), int'(m_pout));
        check("out_valid", int'(out_valid), int'(m_valid));
        check("frame_err", int'(frame_err), int'(m_ferr));
        check("overflow_err", int'(overflow_err), int'(m_oerr));
        check("parity_err", int'(parity_err), 0);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic r_mid, input logic r_last);
        for (int i = 0; i < WIDTH; i++)
            step(1'b0, 1'b1, w[i], i == WIDTH - 1, (i == WIDTH - 1) ? r_last : r_mid);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_pout", int'(parallel_out), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_oerr", int'(overflow_err), 0);
        send(4'hA, 1'b1, 1'b1);
        check("basic_word", int'(parallel_out), 'hA);
        check("basic_valid", int'(out_valid), 1);
        idle(1, 1'b1);
        check("basic_drain", int'(out_valid), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("gap_no_early", int'(out_valid), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("gap_word", int'(parallel_out), 'hB);
        idle(1, 1'b1);
        send(4'h3, 1'b0, 1'b0);
        send(4'hC, 1'b0, 1'b0);
        check("ovf_keep", int'(parallel_out), 'h3);
        check("ovf_flag", int'(overflow_err), 1);
        idle(1, 1'b1);
        check("ovf_drain", int'(out_valid), 0);
        check("ovf_sticky", int'(overflow_err), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_reset", int'(overflow_err), 0);
        send(4'h5, 1'b0, 1'b0);
        send(4'h9, 1'b0, 1'b1);
        check("b2b_word", int'(parallel_out), 'h9);
        check("b2b_valid", int'(out_valid), 1);
        idle(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_pulse", int'(frame_err), 1);
        idle(1, 1'b1);
        check("abort_single", int'(frame_err), 0);
        send(4'h6, 1'b1, 1'b1);
        check("abort_clean", int'(parallel_out), 'h6);
        idle(1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_no_ferr", int'(frame_err), 0);
        send(4'h1, 1'b1, 1'b1);
        check("rst_word", int'(parallel_out), 'h1);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
